vga_capture: RTL and testbench
==============================

# vga_capture

Frame-grabber that is the receive end of the VGA pixel interface: it samples an incoming 12-bit RGB pixel stream with active-low hsync/vsync, recovers the horizontal/vertical position, and writes a fixed W×H window of one frame into the 12-bit-wide block RAM that the VGA output path later reads. One capture runs per start request. The block sits between the video input pins (or a test pattern source) and the BRAM write port.

## Interface
- HBP, 144, pixel ticks from hsync falling edge to first active column
- VBP, 35, lines from vsync falling edge to first active line
- C1, 100, window column offset within the active area
- R1, 100, window row offset within the active area
- W, 256, window width in pixels
- H, 256, window height in lines
- ADDR_W, 16, BRAM write address width; W*H ≤ 2^ADDR_W
- clk  in  1  system clock; one clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- pix_en  in  1  pixel-tick enable; inputs below are sampled only when high
- hsync  in  1  horizontal sync, active low
- vsync  in  1  vertical sync, active low
- red, green, blue  in  4 each  pixel colour
- start  in  1  capture request; sampled every cycle
- busy  out  1  high in ARM and CAPTURE
- done  out  1  one-cycle pulse on successful completion
- error  out  1  sticky: frame ended before window complete
- wr_en  out  1  BRAM write strobe
- wr_addr  out  ADDR_W  BRAM write address
- wr_data  out  12  {red, green, blue}

## Operation
- Sync edge detect: hs_d/vs_d hold hsync/vsync from the previous pix_en tick (reset to 1). Falling edge = previous 1, current 0.
- Position counters hc (10 b), vc (10 b), updated only on pix_en ticks. hsync fall: hc←0; also vsync fall on the same tick: vc←0, else vc←vc+1 (saturate 1023). No hsync fall: hc←hc+1 (saturate 1023). A pixel's position is the counter value after its tick's update.
- In-window: HBP+C1 ≤ hc < HBP+C1+W and VBP+R1 ≤ vc < VBP+R1+H.
- FSM states IDLE, ARM, CAPTURE, DONE.
- IDLE: start=1 → ARM; clears error, write address counter ←0.
- ARM: wait for vsync falling edge on a pix_en tick → CAPTURE (that tick is position 0,0; never in-window).
- CAPTURE: each pix_en tick with in-window pixel issues one write at the current address, then address+1. The write of address W*H−1 → DONE. A vsync falling edge before that → error←1, IDLE, no done.
- DONE: one cycle, done=1, → IDLE.
- start while busy or in DONE is ignored. Pixels are never written outside CAPTURE.
- Address increments linearly, row-major; wraps only by completion, never mid-frame.

## Timing
- Reset (async assert): state IDLE; busy, done, error, wr_en = 0; wr_addr, wr_data = 0; hc, vc = 0; hs_d, vs_d = 1. Deassertion synchronised by the team's standard reset release.
- Write latency: pixel sampled at edge t → wr_en/wr_addr/wr_data valid in cycle t+1 (registered), wr_en high exactly one cycle.
- done coincides with the final wr_en cycle (address W*H−1); busy low in that cycle.
- start→ARM: one cycle (busy high cycle after start sampled).
- pix_en may be high every cycle or every Nth cycle; no behaviour depends on N.
- hsync and vsync falling on the same tick: both handled on that tick as above.

## Test plan
- Reset mid-CAPTURE (after 1000 writes): all outputs 0 immediately, no further wr_en; new start captures cleanly from address 0.
- Standard timing (pix_en every 4th clk, 799-tick lines, hsync low first 128 ticks, vsync low first 3 of 524 lines), data = {vc[3:0], hc[3:0], hc[7:4]}, start pulse → exactly 65536 writes, first at addr 0 with position (244,135), last at addr 65535 with (499,390); done one pulse with final write.
- start held high during capture and during DONE → only one capture; a new capture begins only after IDLE re-samples start.
- Short frame: vsync fall at line 200 during CAPTURE → error=1, no done, busy low; next start clears error.
- start asserted mid-frame → no writes until next vsync falling edge; captured data matches the following frame only.
- pix_en every cycle with W=4, H=2, C1=R1=0 → 8 writes, addresses 0–7, done with write 7.

Source files
------------

// File: rtl/vga_capture.sv
// Frame grabber: recovers raster position from hsync/vsync on pixel ticks and writes
// one W x H window of the next full frame into BRAM, once per start request.
module vga_capture #(
  parameter int HBP    = 144,
  parameter int VBP    = 35,
  parameter int C1     = 100,
  parameter int R1     = 100,
  parameter int W      = 256,
  parameter int H      = 256,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pix_en,
  input  logic              hsync,
  input  logic              vsync,
  input  logic [3:0]        red,
  input  logic [3:0]        green,
  input  logic [3:0]        blue,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int H_LO = HBP + C1;
  localparam int H_HI = HBP + C1 + W;
  localparam int V_LO = VBP + R1;
  localparam int V_HI = VBP + R1 + H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(W * H - 1);

  state_t            state;
  logic [1:0]        rst_sync;
  logic              rst_n_int;
  logic              hs_d, vs_d;
  logic [9:0]        hc, vc;
  logic [9:0]        hc_nx, vc_nx;
  logic              hs_fall, vs_fall, in_win;
  logic [ADDR_W-1:0] addr;

  // Reset asserts asynchronously, releases two clocks after reset_n rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_int = rst_sync[1];

  assign state_dbg = state;

  // Position of the pixel presented on this tick (counter value after update).
  always_comb begin
    hs_fall = hs_d & ~hsync;
    vs_fall = vs_d & ~vsync;
    hc_nx   = hc;
    vc_nx   = vc;
    if (hs_fall) begin
      hc_nx = '0;
      if (vs_fall)             vc_nx = '0;
      else if (vc != 10'd1023) vc_nx = vc + 10'd1;
    end else if (hc != 10'd1023) begin
      hc_nx = hc + 10'd1;
    end
    in_win = (int'(hc_nx) >= H_LO) && (int'(hc_nx) < H_HI) &&
             (int'(vc_nx) >= V_LO) && (int'(vc_nx) < V_HI);
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      hs_d <= 1'b1;
      vs_d <= 1'b1;
      hc   <= '0;
      vc   <= '0;
    end else if (pix_en) begin
      hs_d <= hsync;
      vs_d <= vsync;
      hc   <= hc_nx;
      vc   <= vc_nx;
    end
  end

  // A vsync fall in CAPTURE outranks a window pixel: the frame is over.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      addr    <= '0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_ARM;
            busy  <= 1'b1;
            error <= 1'b0;
            addr  <= '0;
          end
        end
        ST_ARM: begin
          if (pix_en && vs_fall) state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (pix_en) begin
            if (vs_fall) begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else if (in_win) begin
              wr_en   <= 1'b1;
              wr_addr <= addr;
              wr_data <= {red, green, blue};
              addr    <= addr + ADDR_W'(1);
              if (addr == LAST_ADDR) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= ST_DONE;
              end
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture on a miniature raster; pixel data encodes {frame, line, tick}
// so every captured word identifies where and in which frame it was sampled.
module tb_vga_capture;
  localparam int HBP = 4, VBP = 2, C1 = 2, R1 = 1, W = 4, H = 3, ADDR_W = 4;
  localparam int NWORDS = W * H;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NWORDS - 1);

  logic clk = 1'b0, reset_n, pix_en, hsync, vsync, start;
  logic [3:0] red, green, blue;
  logic busy, done, error, wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [11:0] wr_data;
  logic [1:0] state_dbg;

  int checks = 0, errors = 0;
  int pix_div = 4, line_len = 20, hs_len = 2, frame_len = 12, vs_len = 1;
  int h_t = 0, v_t = 0, frame_n = 0;
  int done_cnt = 0, done_ok_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];

  vga_capture #(.HBP(HBP), .VBP(VBP), .C1(C1), .R1(R1), .W(W), .H(H), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue), .start(start), .busy(busy), .done(done),
    .error(error), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // video source: one pixel per pix_div clocks
  initial begin
    pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1; red = '0; green = '0; blue = '0;
    forever begin
      for (int k = 1; k < pix_div; k++) begin
        @(negedge clk);
        pix_en = 1'b0;
      end
      @(negedge clk);
      pix_en = 1'b1;
      hsync  = (h_t < hs_len) ? 1'b0 : 1'b1;
      vsync  = (v_t < vs_len) ? 1'b0 : 1'b1;
      {red, green, blue} = {4'(frame_n), 4'(v_t), 4'(h_t)};
      if (h_t == line_len - 1) begin
        h_t = 0;
        if (v_t >= frame_len - 1) begin
          v_t = 0;
          frame_n++;
        end else v_t++;
      end else h_t++;
    end
  end

  // write monitor
  always @(negedge clk) begin
    if (wr_en) got_q.push_back({wr_addr, wr_data});
    if (done) begin
      done_cnt++;
      if (wr_en && !busy && wr_addr == LAST) done_ok_cnt++;
    end
  end

  function automatic void build_exp(input int f, input int nw);
    for (int a = 0; a < nw; a++)
      exp_q.push_back({4'(a), 4'(f), 4'(VBP + R1 + a / W), 4'(HBP + C1 + a % W)});
  endfunction

  task automatic wait_frame(input int n);
    for (int i = 0; i < 20000 && frame_n < n; i++) @(negedge clk);
  endtask

  task automatic wait_line(input int v);
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (v_t == v) break;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    #23;
    checks += 7;
    if (busy !== 1'b0)    begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (done !== 1'b0)    begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
    if (error !== 1'b0)   begin errors++; $display("FAIL rst_error: got %b expected 0", error); end
    if (wr_en !== 1'b0)   begin errors++; $display("FAIL rst_wr_en: got %b expected 0", wr_en); end
    if (wr_addr !== '0)   begin errors++; $display("FAIL rst_wr_addr: got %h expected 0", wr_addr); end
    if (wr_data !== '0)   begin errors++; $display("FAIL rst_wr_data: got %h expected 0", wr_data); end
    if (state_dbg !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", state_dbg); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_start_mid_frame();
    int f, d0;
    logic [15:0] g, e;
    wait_line(6);
    f = frame_n; d0 = done_cnt;
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", busy); end
    wait_frame(f + 1);
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL mid_early_writes: got %0d expected 0", got_q.size()); end
    wait_frame(f + 2);
    build_exp(f + 1, NWORDS);
    checks += 4;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL mid_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    if (done_cnt != d0 + 1) begin errors++; $display("FAIL mid_done_cnt: got %0d expected %0d", done_cnt, d0 + 1); end
    if (done_ok_cnt != done_cnt) begin errors++; $display("FAIL mid_done_align: got %0d expected %0d", done_ok_cnt, done_cnt); end
    if (busy !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL mid_end_flags: got busy=%b error=%b expected 0 0", busy, error); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL mid_word: got %h expected %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_start_held();
    int f, d0, seen;
    logic [15:0] g, e;
    wait_line(6);
    f = frame_n; d0 = done_cnt; seen = 0;
    start = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    checks += 2;
    if (seen != 1) begin errors++; $display("FAIL held_done_seen: got %0d expected 1", seen); end
    if (busy !== 1'b0) begin errors++; $display("FAIL held_busy_done: got %b expected 0", busy); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL held_busy_idle: got %b expected 0", busy); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL held_rearm: got %b expected 1", busy); end
    start = 1'b0;
    build_exp(f + 1, NWORDS);
    checks += 2;
    if (got_q.size() != NWORDS) begin errors++; $display("FAIL held_count1: got %0d expected %0d", got_q.size(), NWORDS); end
    if (done_cnt != d0 + 1) begin errors++; $display("FAIL held_done_cnt1: got %0d expected %0d", done_cnt, d0 + 1); end
    wait_frame(f + 3);
    build_exp(f + 2, NWORDS);
    checks += 2;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL held_count2: got %0d expected %0d", got_q.size(), exp_q.size()); end
    if (done_cnt != d0 + 2) begin errors++; $display("FAIL held_done_cnt2: got %0d expected %0d", done_cnt, d0 + 2); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL held_word: got %h expected %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_short_frame();
    int f, d0;
    logic [15:0] g, e;
    wait_line(6);
    f = frame_n; d0 = done_cnt;
    pulse_start();
    wait_frame(f + 1);
    frame_len = 5;
    wait_frame(f + 2);
    frame_len = 12;
    repeat (20) @(negedge clk);
    build_exp(f + 1, 2 * W);
    checks += 4;
    if (error !== 1'b1) begin errors++; $display("FAIL short_error: got %b expected 1", error); end
    if (busy !== 1'b0) begin errors++; $display("FAIL short_busy: got %b expected 0", busy); end
    if (done_cnt != d0) begin errors++; $display("FAIL short_no_done: got %0d expected %0d", done_cnt, d0); end
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL short_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL short_word: got %h expected %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    f = frame_n;
    pulse_start();
    checks += 2;
    if (error !== 1'b0) begin errors++; $display("FAIL short_error_clear: got %b expected 0", error); end
    if (busy !== 1'b1) begin errors++; $display("FAIL short_rearm: got %b expected 1", busy); end
    wait_frame(f + 2);
    build_exp(f + 1, NWORDS);
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL short_next_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL short_next_word: got %h expected %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid_capture();
    int f, n;
    logic [15:0] g, e;
    wait_line(6);
    f = frame_n;
    pulse_start();
    for (int i = 0; i < 3000 && got_q.size() < 5; i++) @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    checks += 5;
    if (busy !== 1'b0)  begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    if (wr_en !== 1'b0) begin errors++; $display("FAIL rmid_wr_en: got %b expected 0", wr_en); end
    if (wr_addr !== '0) begin errors++; $display("FAIL rmid_wr_addr: got %h expected 0", wr_addr); end
    if (wr_data !== '0) begin errors++; $display("FAIL rmid_wr_data: got %h expected 0", wr_data); end
    if (state_dbg !== 2'd0) begin errors++; $display("FAIL rmid_state: got %0d expected 0", state_dbg); end
    n = got_q.size();
    repeat (40) @(negedge clk);
    checks++;
    if (got_q.size() != n) begin errors++; $display("FAIL rmid_no_writes: got %0d expected %0d", got_q.size(), n); end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    got_q.delete();
    wait_line(6);
    f = frame_n;
    pulse_start();
    wait_frame(f + 2);
    build_exp(f + 1, NWORDS);
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rmid_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL rmid_word: got %h expected %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_fast_pix();
    int f, d0;
    logic [15:0] g, e;
    pix_div = 1;
    wait_line(6);
    f = frame_n; d0 = done_cnt;
    pulse_start();
    wait_frame(f + 2);
    build_exp(f + 1, NWORDS);
    checks += 3;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL fast_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    if (done_cnt != d0 + 1) begin errors++; $display("FAIL fast_done_cnt: got %0d expected %0d", done_cnt, d0 + 1); end
    if (done_ok_cnt != done_cnt) begin errors++; $display("FAIL fast_done_align: got %0d expected %0d", done_ok_cnt, done_cnt); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL fast_word: got %h expected %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    test_reset();
    test_start_mid_frame();
    test_start_held();
    test_short_frame();
    test_reset_mid_capture();
    test_fast_pix();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
